// File: rtl/gray_run_arbiter.sv
// gray_run_arbiter: two-requester round-robin arbiter that sequences one
// counting run at a time on a shared binary/Gray counter.
module gray_run_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             set,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q,   ptr_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] len_q,   len_d;
  logic             winner;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Pick the requester for the next grant: a lone request wins, a tie goes
  // to whoever did not win last time.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = ~ptr_q;
    else              winner = req[1];
  end

  // Next-state logic: grant from IDLE, count or finish in RUN, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          owner_d = winner;
          ptr_d   = winner;
          cnt_d   = '0;
          len_d   = winner ? len1 : len0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Dropping the request aborts without a done pulse, even on the
        // terminal count.
        if (!req[owner_q])        state_d = IDLE;
        else if (cnt_q == len_q)  state_d = DONE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and count registers, cleared asynchronously; pointer starts at 1
  // so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Run length captured at grant; only read while a run is active.
  always_ff @(posedge clk) begin
    len_q <= len_d;
  end

  assign gnt      = (state_q == RUN)  ? onehot(owner_q) : 2'b00;
  assign done     = (state_q == DONE) ? onehot(owner_q) : 2'b00;
  assign busy     = (state_q != IDLE);
  assign cnt_bin  = cnt_q;
  assign cnt_gray = bin2gray(cnt_q);

endmodule

// File: tb/tb_gray_run_arbiter.sv
// Self-checking bench for gray_run_arbiter: directed scenarios followed by
// random request traffic, compared against a run-level reference model.
module tb_gray_run_arbiter;

  logic       clk = 1'b0;
  logic       set;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] gnt, done;
  logic       busy;
  logic [3:0] cnt_bin, cnt_gray;

  int errors = 0;
  int checks = 0;

  // reference model: phase 0 = idle, 1 = counting, 2 = completion cycle
  int m_phase, m_owner, m_last, m_cnt, m_len;
  logic [3:0] gray_tab [16];

  gray_run_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .set(set), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .busy(busy), .done(done), .cnt_bin(cnt_bin), .cnt_gray(cnt_gray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 1; m_cnt = 0; m_len = 0;
  endtask

  task automatic model_edge();
    int w;
    case (m_phase)
      0: if (req != 2'b00) begin
        if (req == 2'b11) w = 1 - m_last;
        else              w = req[1] ? 1 : 0;
        m_owner = w; m_last = w; m_cnt = 0;
        m_len = (w == 1) ? int'(len1) : int'(len0);
        m_phase = 1;
      end
      1: begin
        if (!req[m_owner])       m_phase = 0;
        else if (m_cnt == m_len) m_phase = 2;
        else                     m_cnt = m_cnt + 1;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    logic [1:0] eg, ed;
    eg = (m_phase == 1) ? 2'(1 << m_owner) : 2'b00;
    ed = (m_phase == 2) ? 2'(1 << m_owner) : 2'b00;
    check("gnt",      {2'b00, gnt},  {2'b00, eg});
    check("done",     {2'b00, done}, {2'b00, ed});
    check("busy",     {3'b000, busy}, {3'b000, (m_phase != 0)});
    check("cnt_bin",  cnt_bin,  4'(m_cnt));
    check("cnt_gray", cnt_gray, gray_tab[m_cnt]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reflected Gray code table built by mirroring
    gray_tab[0] = 4'd0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < (1 << k); j++)
        gray_tab[(1 << k) + j] = gray_tab[(1 << k) - 1 - j] | 4'(1 << k);

    set = 1'b1; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
    model_reset();
    #2;
    check_all();
    #10 set = 1'b0;

    // single run, requester 0, length 3
    req = 2'b01; len0 = 4'd3;
    steps(6);
    req = 2'b00;
    steps(2);

    // tie with both held: order 0,1,0
    req = 2'b11; len0 = 4'd1; len1 = 4'd2;
    steps(14);
    req = 2'b00;
    steps(3);

    // full length on requester 1, no wrap
    req = 2'b10; len1 = 4'd15;
    steps(16);
    check("full_last_bin",  cnt_bin,  4'd15);
    check("full_last_gray", cnt_gray, 4'b1000);
    step();
    check("full_done", {2'b00, done}, 4'b0010);
    req = 2'b00;
    steps(2);

    // abort when count reaches 2
    req = 2'b01; len0 = 4'd7;
    for (int i = 0; i < 20 && !(m_phase == 1 && m_cnt == 2); i++) step();
    check("abort_reached", 4'(m_cnt), 4'd2);
    req = 2'b00;
    step();
    check("abort_hold", cnt_bin, 4'd2);
    steps(2);

    // asynchronous reset mid-run at count 5
    req = 2'b01; len0 = 4'd9;
    for (int i = 0; i < 20 && !(m_phase == 1 && m_cnt == 5); i++) step();
    check("rst_reached", 4'(m_cnt), 4'd5);
    #3 set = 1'b1;
    model_reset();
    #1;
    check_all();
    #2 set = 1'b0;
    req = 2'b11; len0 = 4'd2; len1 = 4'd2;
    step();
    check("rst_tie_winner", {2'b00, gnt}, 4'b0001);
    steps(10);
    req = 2'b00;
    steps(3);

    // zero length, len0 changed after grant
    req = 2'b01; len0 = 4'd0;
    step();
    len0 = 4'd9;
    step();
    check("zero_done", {2'b00, done}, 4'b0001);
    req = 2'b00;
    steps(3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
      if ($urandom_range(0, 3) == 0) len0 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) len1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_run_arbiter.md
Name: gray_run_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4-bit Gray-code count resource.
- Two requesters each ask for one counting run of programmable length.
- The block grants the counter to one requester at a time and sequences the run.
- During a run it drives binary and Gray count values, then signals completion.
- It sits between the requesting control logic and the Gray counter output path.

Parameters:
- WIDTH, 4, width of count, length and Gray outputs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- set  input  1  reset; asynchronous, active-high.
- req  input  2  per-requester run request; level, held high for the whole run.
- len0  input  WIDTH  last count value for requester 0; sampled at grant.
- len1  input  WIDTH  last count value for requester 1; sampled at grant.
- gnt  output  2  one-hot grant; high for every RUN cycle of the owner.
- busy  output  1  high while state is RUN or DONE.
- done  output  2  one-cycle completion pulse to the owning requester.
- cnt_bin  output  WIDTH  current binary count.
- cnt_gray  output  WIDTH  Gray code of cnt_bin, defined as cnt_bin XOR (cnt_bin>>1), valid in the same cycle.

Behaviour:
- Reset (set=1, asynchronous):
  - state=IDLE; gnt=0, done=0, busy=0, cnt_bin=0, cnt_gray=0.
  - Internal last-winner pointer = 1, so requester 0 wins the first tie.
- States: IDLE, RUN, DONE. All outputs are registered or derived from registered state only.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, that requester wins.
  - If both req, the requester not equal to the last-winner pointer wins.
  - On the edge that grants: latch winner's len into len_q, gnt[winner]=1, cnt_bin=0, pointer=winner, state=RUN.
  - Latency: req high before edge k gives gnt high after edge k.
- RUN:
  - Each edge: if req[owner]=0, abort.
    - Abort: state=IDLE, gnt=0, no done pulse, cnt_bin holds.
  - Else if cnt_bin==len_q: state=DONE, gnt=0, done[owner]=1, cnt_bin holds.
  - Else cnt_bin=cnt_bin+1.
  - A run lasts len_q+1 RUN cycles, with counts 0..len_q inclusive. len_q=0 gives a single cycle.
  - The counter never wraps: len_q max = 2^WIDTH-1 is a terminal value, not a wrap.
- DONE:
  - One cycle only. done pulse is visible this cycle, busy=1, gnt=0.
  - Next edge: done=0, state=IDLE.
- After a run, cnt_bin and cnt_gray hold their final value through DONE and IDLE until the next grant clears them to 0.
- Timing and input rules:
  - Minimum gap between the last RUN cycle of one grant and the first RUN cycle of the next is 2 cycles (DONE + IDLE).
  - len0/len1 changes after grant have no effect on the current run.
  - req of the non-owner is ignored until IDLE.
- Simultaneous abort and terminal count: abort wins, so no done pulse.
- Reset mid-run: immediate return to reset values; the pointer resets to 1.

Test Plan:
- Single run: req=01, len0=3 → gnt=01 for 4 cycles; cnt_gray 0,1,3,2; then done=01 for 1 cycle, busy falls 1 cycle later.
- Tie and fairness: req=11 held, len0=1, len1=2 → grant order 0,1,0; gnt low for 2 cycles between runs; done alternates 01,10.
- Full length: req=10, len1=15 → 16 RUN cycles; last cnt_bin=15, cnt_gray=1000; no wrap to 0; done=10.
- Abort: req=01, len0=7, drop req[0] when cnt_bin=2 → gnt=00 next edge, done stays 00, cnt_bin holds 2, state IDLE.
- Reset mid-run: assert set when cnt_bin=5 (asynchronous, between edges) → gnt, busy, cnt_bin and cnt_gray go to 0 immediately; after release with req=11, requester 0 wins.
- Zero length and latch: len0=0, change len0 to 9 after grant → exactly 1 RUN cycle at cnt_bin=0, then done=01.
